// File: rtl/axi_rt_cfg_sequencer.sv
// Register-bus initiator that writes a parameter-sized table into the RT unit config port and can read it back to verify.
// One request is in flight at a time; timeouts, bus errors and read-back mismatches end the sequence.
module axi_rt_cfg_sequencer #(
   parameter int unsigned NumEntries    = 8,
   parameter int unsigned AddrWidth     = 32,
   parameter bit          VerifyEn      = 1'b1,
   parameter int unsigned TimeoutCycles = 256,
   localparam int unsigned IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            start_i,
   input  logic [NumEntries*AddrWidth-1:0] tbl_addr_i,
   input  logic [NumEntries*32-1:0]        tbl_data_i,
   input  logic [NumEntries-1:0]           tbl_en_i,
   output logic [AddrWidth-1:0]            cfg_addr_o,
   output logic [31:0]                     cfg_wdata_o,
   output logic [3:0]                      cfg_wstrb_o,
   output logic                            cfg_write_o,
   output logic                            cfg_valid_o,
   input  logic [31:0]                     cfg_rdata_i,
   input  logic                            cfg_error_i,
   input  logic                            cfg_ready_i,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            error_o,
   output logic [IdxW-1:0]                 err_idx_o,
   output logic [1:0]                      err_code_o
);

   localparam int unsigned TW = $clog2(TimeoutCycles + 1);

   typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, FINISH} state_e;

   state_e               state_q;
   logic [IdxW-1:0]      idx_q;
   logic [TW-1:0]        tmo_q;
   logic [AddrWidth-1:0] addr_q;
   logic [31:0]          wdata_q;
   logic [3:0]           wstrb_q;
   logic                 write_q, valid_q, busy_q, done_q, error_q;
   logic [IdxW-1:0]      err_idx_q;
   logic [1:0]           err_code_q;

   logic                 first_vld, nxt_vld;
   logic [IdxW-1:0]      first_idx, nxt_idx, sel_idx;
   logic [AddrWidth-1:0] cur_addr;
   logic [31:0]          cur_data;

   // In IDLE the first request is launched straight from the first enabled entry.
   assign sel_idx = (state_q == IDLE) ? first_idx : idx_q;

   always_comb begin
      first_vld = 1'b0;
      first_idx = '0;
      nxt_vld   = 1'b0;
      nxt_idx   = '0;
      cur_addr  = '0;
      cur_data  = '0;
      for (int unsigned i = 0; i < NumEntries; i++) begin
         if (tbl_en_i[i] && !first_vld) begin
            first_vld = 1'b1;
            first_idx = IdxW'(i);
         end
         if (tbl_en_i[i] && !nxt_vld && (IdxW'(i) > idx_q)) begin
            nxt_vld = 1'b1;
            nxt_idx = IdxW'(i);
         end
         if (sel_idx == IdxW'(i)) begin
            cur_addr = tbl_addr_i[i*AddrWidth +: AddrWidth];
            cur_data = tbl_data_i[i*32 +: 32];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         tmo_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         write_q    <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_idx_q  <= '0;
         err_code_q <= 2'b00;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  error_q    <= 1'b0;
                  err_idx_q  <= '0;
                  err_code_q <= 2'b00;
                  busy_q     <= 1'b1;
                  tmo_q      <= '0;
                  idx_q      <= first_idx;
                  if (first_vld) begin
                     state_q <= WR_REQ;
                     valid_q <= 1'b1;
                     write_q <= 1'b1;
                     addr_q  <= cur_addr;
                     wdata_q <= cur_data;
                     wstrb_q <= 4'hF;
                  end else begin
                     state_q <= FINISH;
                  end
               end
            end
            WR_REQ, RD_REQ: begin
               if (!valid_q) begin
                  valid_q <= 1'b1;
                  write_q <= (state_q == WR_REQ);
                  addr_q  <= cur_addr;
                  wdata_q <= (state_q == WR_REQ) ? cur_data : 32'h0;
                  wstrb_q <= (state_q == WR_REQ) ? 4'hF : 4'h0;
               end else if (cfg_ready_i) begin
                  valid_q <= 1'b0;
                  tmo_q   <= '0;
                  if (cfg_error_i) begin
                     error_q    <= 1'b1;
                     err_code_q <= 2'b01;
                     err_idx_q  <= idx_q;
                     state_q    <= FINISH;
                  end else if (state_q == RD_REQ && cfg_rdata_i != cur_data) begin
                     error_q    <= 1'b1;
                     err_code_q <= 2'b10;
                     err_idx_q  <= idx_q;
                     state_q    <= FINISH;
                  end else if (nxt_vld) begin
                     idx_q <= nxt_idx;
                  end else if (state_q == WR_REQ && VerifyEn) begin
                     state_q <= RD_REQ;
                     idx_q   <= first_idx;
                  end else begin
                     state_q <= FINISH;
                  end
               end else if (tmo_q == TW'(TimeoutCycles - 1)) begin
                  // Saturate at the limit so the counter can never wrap.
                  tmo_q      <= TW'(TimeoutCycles);
                  valid_q    <= 1'b0;
                  error_q    <= 1'b1;
                  err_code_q <= 2'b11;
                  err_idx_q  <= idx_q;
                  state_q    <= FINISH;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            FINISH: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cfg_addr_o  = addr_q;
   assign cfg_wdata_o = wdata_q;
   assign cfg_wstrb_o = wstrb_q;
   assign cfg_write_o = write_q;
   assign cfg_valid_o = valid_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign error_o     = error_q;
   assign err_idx_o   = err_idx_q;
   assign err_code_o  = err_code_q;

endmodule
